alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
Multi-cycle controller that sits in front of the shared 16-bit ALU and drives its A, B and ALUK inputs. It executes the four native ALU ops in one pass. It also builds the extended ops SUB, NEG, OR and DBL from several ALU passes, holding intermediate values in internal temp registers. The issuing logic (datapath FSM or testbench) sees a single start/busy/done interface.

Parameters:
WIDTH, 16, operand/result width; must match the ALU.

Ports:
Clk  in  1  system clock, rising-edge.
Reset  in  1  asynchronous, active-high reset.
Start  in  1  request; sampled on a rising edge only while Busy=0.
OP  in  3  op select: 0 ADD, 1 AND, 2 NOT, 3 PSA, 4 SUB, 5 NEG, 6 OR, 7 DBL.
A  in  WIDTH  operand A; latched into RA on acceptance.
B  in  WIDTH  operand B; latched into RB on acceptance.
ALU_OUT  in  WIDTH  combinational result from the ALU.
ALU_A  out  WIDTH  ALU A input.
ALU_B  out  WIDTH  ALU B input.
ALUK  out  2  ALU op code: ADD=00, AND=01, NOT=10, PSA=11 (ALU_OPS values).
RESULT  out  WIDTH  final result; holds until the next completion.
Busy  out  1  high while an op is in progress.
Done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, active-high): state IDLE, step=0; RA, RB, T0, T1, RESULT = 0; Busy=0, Done=0. An in-progress op is aborted and produces no Done.
- States: IDLE, EXEC (2-bit step counter 0..3). Done is a registered pulse.
- Accept: on the edge E0 where Start=1 and Busy=0:
  - latch OP, RA=A, RB=B; step=0; state EXEC; Busy=1.
  - A Start while Busy=1 is ignored; no queuing.
- Pass timing:
  - Pass k is driven combinationally during the cycle after edge E(k), with ALUK/ALU_A/ALU_B decoded from (OP, step).
  - ALU_OUT is captured into the pass's destination at E(k+1); step then increments.
- Pass table (unused ALU_B is driven 0):
  - ADD/AND: R = RA op RB.
  - NOT: R = ~RA.
  - PSA: R = RA.
  - DBL: R = RA + RA.
  - SUB: s0 T0=~RB; s1 T0=T0+1 (ALU_B=1); s2 R=RA+T0.
  - NEG: s0 T0=~RA; s1 R=T0+1.
  - OR: s0 T0=~RA; s1 T1=~RB; s2 T0=T0&T1; s3 R=~T0.
- Latency in passes: ADD/AND/NOT/PSA/DBL = 1, NEG = 2, SUB = 3, OR = 4.
- Completion edge En (n = latency):
  - RESULT = ALU_OUT; state IDLE; Busy=0; Done=1 for exactly the cycle after En.
- Back-to-back: Start may be asserted in the Done cycle (Busy=0) and is accepted at that cycle's edge.
- Idle outputs: ALU_A=0, ALU_B=0, ALUK=PSA.
- Arithmetic wraps mod 2^WIDTH; no carry or overflow outputs. NEG of 0x8000 = 0x8000.
- Inputs A, B and OP may change freely after acceptance; only the latched copies are used.

Test Plan:
1. Reset, then ADD A=0x7FFF B=0x0001 -> one pass with ALUK=00. RESULT=0x8000, Done high the cycle after E1, Busy high for 1 cycle.
2. SUB A=0x0005 B=0x0007 -> ALUK sequence 10,00,00 with ALU_B=1 on s1. RESULT=0xFFFE, Done after E3.
3. OR A=0x00F0 B=0x0F00 -> ALUK sequence 10,10,01,10. RESULT=0x0FF0, Done after E4. Also OR 0xFFFF|0 -> 0xFFFF.
4. NEG 0x0000 -> 0x0000. NEG 0x8000 -> 0x8000. NEG 0x0001 -> 0xFFFF. Each with 2-pass latency.
5. Pulse Start with ADD 1+1 while an OR is busy -> ignored; the OR's RESULT and timing are unchanged. Then assert Start (DBL A=0x4001) in the Done cycle -> accepted; RESULT=0x8002 one pass later.
6. Assert Reset asynchronously mid-cycle during OR step 2 -> Busy=0 and Done=0 immediately; RESULT=0. No Done follows; the next Start behaves as from power-up.

Source files
------------

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer in front of the shared ALU: runs native ops in one pass
// and builds SUB/NEG/OR/DBL from several passes through internal temp registers.
module alu_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] ALU_OUT,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [1:0]       ALUK,
  output logic [WIDTH-1:0] RESULT,
  output logic             Busy,
  output logic             Done
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_AND = 3'd1;
  localparam logic [2:0] OP_NOT = 3'd2;
  localparam logic [2:0] OP_PSA = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_NEG = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_DBL = 3'd7;

  localparam logic [1:0] K_ADD = 2'b00;
  localparam logic [1:0] K_AND = 2'b01;
  localparam logic [1:0] K_NOT = 2'b10;
  localparam logic [1:0] K_PSA = 2'b11;

  typedef enum logic {IDLE, EXEC} state_t;
  typedef enum logic [1:0] {DST_T0, DST_T1, DST_R} dst_t;

  state_t           state_q, state_d;
  logic [1:0]       step_q, step_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d;
  logic [WIDTH-1:0] t0_q, t0_d, t1_q, t1_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;

  logic [1:0]       aluk_c;
  logic [WIDTH-1:0] alu_a_c, alu_b_c;
  dst_t             dst_c;

  // Pass decode: ALU controls and capture destination from (op, step)
  always_comb begin
    aluk_c  = K_PSA;
    alu_a_c = '0;
    alu_b_c = '0;
    dst_c   = DST_R;
    if (state_q == EXEC) begin
      case (op_q)
        OP_ADD: begin aluk_c = K_ADD; alu_a_c = ra_q; alu_b_c = rb_q; end
        OP_AND: begin aluk_c = K_AND; alu_a_c = ra_q; alu_b_c = rb_q; end
        OP_NOT: begin aluk_c = K_NOT; alu_a_c = ra_q; end
        OP_PSA: begin aluk_c = K_PSA; alu_a_c = ra_q; end
        OP_DBL: begin aluk_c = K_ADD; alu_a_c = ra_q; alu_b_c = ra_q; end
        OP_SUB: begin
          case (step_q)
            2'd0:    begin aluk_c = K_NOT; alu_a_c = rb_q; dst_c = DST_T0; end
            2'd1:    begin aluk_c = K_ADD; alu_a_c = t0_q; alu_b_c = WIDTH'(1); dst_c = DST_T0; end
            default: begin aluk_c = K_ADD; alu_a_c = ra_q; alu_b_c = t0_q; end
          endcase
        end
        OP_NEG: begin
          if (step_q == 2'd0) begin
            aluk_c = K_NOT; alu_a_c = ra_q; dst_c = DST_T0;
          end else begin
            aluk_c = K_ADD; alu_a_c = t0_q; alu_b_c = WIDTH'(1);
          end
        end
        default: begin // OR via De Morgan: ~(~a & ~b)
          case (step_q)
            2'd0:    begin aluk_c = K_NOT; alu_a_c = ra_q; dst_c = DST_T0; end
            2'd1:    begin aluk_c = K_NOT; alu_a_c = rb_q; dst_c = DST_T1; end
            2'd2:    begin aluk_c = K_AND; alu_a_c = t0_q; alu_b_c = t1_q; dst_c = DST_T0; end
            default: begin aluk_c = K_NOT; alu_a_c = t0_q; end
          endcase
        end
      endcase
    end
  end

  // Next-state: accept in IDLE, capture ALU_OUT into the pass destination in EXEC
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    op_d     = op_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    t0_d     = t0_q;
    t1_d     = t1_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = EXEC;
          step_d  = 2'd0;
          op_d    = OP;
          ra_d    = A;
          rb_d    = B;
        end
      end
      default: begin
        case (dst_c)
          DST_T0: t0_d = ALU_OUT;
          DST_T1: t1_d = ALU_OUT;
          default: begin
            result_d = ALU_OUT;
            state_d  = IDLE;
            done_d   = 1'b1;
          end
        endcase
        step_d = (dst_c == DST_R) ? 2'd0 : step_q + 2'd1;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      step_q   <= 2'd0;
      op_q     <= 3'd0;
      ra_q     <= '0;
      rb_q     <= '0;
      t0_q     <= '0;
      t1_q     <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      op_q     <= op_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      t0_q     <= t0_d;
      t1_q     <= t1_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign ALU_A  = alu_a_c;
  assign ALU_B  = alu_b_c;
  assign ALUK   = aluk_c;
  assign RESULT = result_q;
  assign Busy   = (state_q == EXEC);
  assign Done   = done_q;

endmodule
